// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline fetch logic.
// Holds the reset fetch address, the instruction-memory depth, the NOP encoding,
// the next-PC select and fetch-FSM encodings.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/npc.sv
// Next-PC selection: jr > j > taken branch > sequential. Redirects only apply
// when IF/ID holds a real instruction.
// Ports:
//   pc_f, pc_d, instr_d, valid_d   - current fetch PC and IF/ID contents
//   br_is, br_true, j_is, jr_is    - decoded control class of the ID instruction
//   rs_fwd                         - forwarded jr target
//   npc                            - next fetch PC
//   npc_sel                        - chosen source (debug/coverage)
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic        br_is,
  input  logic        br_true,
  input  logic        j_is,
  input  logic        jr_is,
  input  logic [31:0] rs_fwd,
  input  logic        valid_d,
  output logic [31:0] npc,
  output logic [1:0]  npc_sel
);

  logic [31:0] seq_tgt;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  npc_sel_e    sel;
  logic        unused_opcode;

  // Opcode field is decoded upstream; only the immediate/index fields matter here.
  assign unused_opcode = ^instr_d[31:26];

  assign seq_tgt = pc_f + 32'd4;
  // Branch offset is relative to the delay-slot address (pc_d + 4).
  assign br_tgt  = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign j_tgt   = {pc_d[31:28], instr_d[25:0], 2'b00};

  // Priority select; an empty IF/ID slot never redirects.
  always_comb begin
    sel = NPC_SEQ;
    if (valid_d) begin
      if (jr_is)                 sel = NPC_JR;
      else if (j_is)             sel = NPC_J;
      else if (br_is && br_true) sel = NPC_BR;
    end
  end

  always_comb begin
    npc = seq_tgt;
    unique case (sel)
      NPC_SEQ: npc = seq_tgt;
      NPC_BR:  npc = br_tgt;
      NPC_J:   npc = j_tgt;
      NPC_JR:  npc = rs_fwd;
      default: npc = seq_tgt;
    endcase
  end

  assign npc_sel = sel;

endmodule

// File: rtl/fetch_npc_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch-fault
// halt FSM and fetched-instruction counter.
// Ports:
//   clk, reset (async, active-high)
//   stall                           - hold PC and IF/ID
//   br_is, br_true, j_is, jr_is, rs_fwd - ID-stage control for next-PC
//   imem_addr / imem_rdata          - fetch PC and combinational instruction read
//   instr_d, pc_d, pc8_d, valid_d   - IF/ID contents (pc8_d = pc_d + 8 link value)
//   fault, fault_pc                 - sticky fetch fault and faulting PC
//   fetch_cnt                       - count of valid IF/ID loads
module fetch_npc_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_is,
  input  logic        br_true,
  input  logic        j_is,
  input  logic        jr_is,
  input  logic [31:0] rs_fwd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] PC_LAST = RESET_PC + 32'(IM_WORDS * 4) - 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  instr_d_q, instr_d_d;
  logic [31:0]  pc_d_q, pc_d_d;
  logic         valid_d_q, valid_d_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;

  logic [31:0]  npc_w;
  logic [1:0]   npc_sel_w;
  logic         pc_fault_c;

  npc u_npc (
    .pc_f    (pc_f_q),
    .pc_d    (pc_d_q),
    .instr_d (instr_d_q),
    .br_is   (br_is),
    .br_true (br_true),
    .j_is    (j_is),
    .jr_is   (jr_is),
    .rs_fwd  (rs_fwd),
    .valid_d (valid_d_q),
    .npc     (npc_w),
    .npc_sel (npc_sel_w)
  );

  // Misaligned or out-of-range fetch address.
  assign pc_fault_c = (pc_f_q[1:0] != 2'b00) || (pc_f_q < RESET_PC) || (pc_f_q > PC_LAST);

  // Next-state: stall freezes everything in RUN; HALT freezes everything regardless.
  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    valid_d_d   = valid_d_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      FS_RUN: begin
        if (!stall) begin
          if (pc_fault_c) begin
            // Bubble into IF/ID; pc_f stays on the faulting address.
            instr_d_d  = NOP;
            pc_d_d     = pc_f_q;
            valid_d_d  = 1'b0;
            fault_d    = 1'b1;
            fault_pc_d = pc_f_q;
            state_d    = FS_HALT;
          end else begin
            pc_f_d      = npc_w;
            instr_d_d   = imem_rdata;
            pc_d_d      = pc_f_q;
            valid_d_d   = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
        end
      end
      FS_HALT: begin
      end
      default: state_d = FS_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_RUN;
      pc_f_q      <= RESET_PC;
      instr_d_q   <= NOP;
      pc_d_q      <= 32'd0;
      valid_d_q   <= 1'b0;
      fault_q     <= 1'b0;
      fault_pc_q  <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      valid_d_q   <= valid_d_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr = pc_f_q;
  assign instr_d   = instr_d_q;
  assign pc_d      = pc_d_q;
  assign pc8_d     = pc_d_q + 32'd8;
  assign valid_d   = valid_d_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/fetch_npc_stage.md
# fetch_npc_stage

Instruction-fetch stage with next-PC selection and the IF/ID pipeline register for the five-stage MIPS pipeline. It consumes the branch-condition output of the ID-stage comparator (`br_true`) together with the decoded jump/branch class, and computes the next fetch PC with one architectural delay slot. It holds PC and IF/ID on hazard stalls and latches fetch faults into a halt state. It also keeps a fetched-instruction counter for the bench and for debug.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- IM_WORDS, 4096, instruction memory depth in words; valid fetch range is RESET_PC .. RESET_PC+4*IM_WORDS-4
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- br_is  input  1  ID instruction is any conditional branch (beq/bne/blez/bgtz/bltz/bgez)
- br_true  input  1  comparator result for the ID instruction
- j_is  input  1  ID instruction is j/jal
- jr_is  input  1  ID instruction is jr/jalr
- rs_fwd  input  32  forwarded rs value in ID (jr target)
- imem_addr  output  32  current fetch PC (pc_f)
- imem_rdata  input  32  instruction word at imem_addr, combinational read
- instr_d  output  32  IF/ID instruction
- pc_d  output  32  IF/ID PC
- pc8_d  output  32  pc_d+8, link value for jal/jalr
- valid_d  output  1  IF/ID holds a real fetched instruction
- fault  output  1  fetch fault latched (sticky until reset)
- fault_pc  output  32  PC that faulted
- fetch_cnt  output  32  number of instructions accepted into IF/ID

## Operation
- State machine: RUN, HALT. Reset enters RUN.
- Fetch fault in RUN: pc_f[1:0]!=0 or pc_f outside valid range, evaluated on the same cycle as fetch.
- Fault with stall=0: the next edge loads IF/ID with instr_d=0 (nop), valid_d=0, sets fault, captures fault_pc=pc_f, and enters HALT.
- Fault with stall=1: no effect; re-evaluated next cycle.
- HALT: pc_f frozen; IF/ID frozen as loaded; stall ignored; only reset leaves HALT.
- Next-PC priority, using the ID instruction (imm16=instr_d[15:0], idx26=instr_d[25:0]):
  - jr_is → rs_fwd.
  - j_is → {pc_d[31:28], idx26, 2'b00}.
  - br_is && br_true → pc_d + 4 + (sign_ext(imm16) << 2), modulo 2^32.
  - otherwise pc_f + 4.
- Branch/jump redirects only when valid_d=1; with valid_d=0, next-PC is pc_f+4.
- Delay slot: the instruction at pc_d+4, already being fetched in IF, always enters IF/ID; no flush exists.
- RUN, stall=0, no fault: pc_f <= npc; instr_d <= imem_rdata; pc_d <= pc_f; valid_d <= 1; fetch_cnt += 1 (wraps at 2^32).
- RUN, stall=1: pc_f, IF/ID and fetch_cnt hold; br_true is not acted on, since the comparator operands are stale.
- pc8_d is combinational pc_d+8.

## Timing
- Reset values: pc_f=RESET_PC, instr_d=0, pc_d=0, valid_d=0, fault=0, fault_pc=0, fetch_cnt=0.
- Reset is asynchronous on assertion and takes effect mid-cycle. Deassertion is sampled on the next clk edge, and the first fetch is at RESET_PC on that cycle.
- Fetch-to-ID latency: 1 cycle.
- Branch resolution: redirect is visible on imem_addr one cycle after the branch occupies ID.
- Redirect penalty: zero beyond the delay slot.
- Stall and redirect together: stall wins; the redirect is taken on the first non-stalled cycle.
- fetch_cnt counts IF/ID loads with valid_d=1 only; fault loads and stalled cycles are not counted.

## Structure
- Shared package `mips_pkg`:
  - RESET_PC default.
  - NOP word 32'h0000_0000.
  - npc_sel enum {NPC_SEQ, NPC_BR, NPC_J, NPC_JR}.
  - fetch FSM enum {FS_RUN, FS_HALT}.
- Sub-module `npc`: combinational next-PC mux and target adders.
  - Inputs: pc_f, pc_d, instr_d, control bits, rs_fwd, valid_d.
  - Outputs: npc and npc_sel; npc_sel is exposed for debug and coverage.
- Top level holds the PC register, the IF/ID register, the FSM, the fault logic and the counter.

## Test plan
- Reset sequential fetch: reset high for 2 cycles, then low, no control inputs → imem_addr steps 0x3000, 0x3004, 0x3008; pc_d lags one cycle; fetch_cnt=3 after 3 edges.
- Taken branch: branch at pc_d=0x3004, imm16=0x0003, br_is=br_true=1 → delay slot 0x3008 enters IF/ID, then imem_addr=0x3014.
- Not-taken branch: same as taken, br_true=0 → imem_addr=0x300C.
- Backward branch: imm16=0xFFFF → imem_addr=pc_d.
- j at pc_d=0x3010, idx26=0x0000C10 → imem_addr=0x0000_3040.
- jr with rs_fwd=0x0000_3100 → imem_addr=0x3100.
- Stall over branch: stall=1 for 3 cycles while the taken branch sits in ID → imem_addr, instr_d and fetch_cnt are frozen; redirect occurs on the first stall=0 edge.
- Fault: jr to 0x0000_3102 → fault=1, fault_pc=0x3102, instr_d=0, valid_d=0, FSM HALT with imem_addr frozen; async reset mid-cycle returns pc_f=0x3000 and fault=0 before the next edge.
